// File: rtl/rr_mux_arbiter_16_pkg.sv
// Shared definitions for the 16-requester round-robin mux arbiter:
// requester count, select width and the two-state controller encoding.
package rr_mux_arbiter_16_pkg;

    localparam int NUM_REQ = 16;
    localparam int SEL_W   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Next requester index after idx; wraps 15 -> 0 through the 4-bit width.
    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/rr_priority_pick_16.sv
// Combinational round-robin search: first set bit of req at or above ptr,
// modulo 16. Implemented as rotate-right by ptr, then a lowest-bit encoder.
module rr_priority_pick_16
    import rr_mux_arbiter_16_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    logic [NUM_REQ-1:0] rot;
    logic [SEL_W-1:0]   off;

    assign rot = NUM_REQ'({req, req} >> ptr);

    always_comb begin
        off = '0;
        // Descending scan so the lowest set bit of the rotated vector wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = SEL_W'(i);
        end
    end

    assign found = |req;
    assign idx   = ptr + off;

endmodule

// File: rtl/rr_mux_arbiter_16.sv
// Round-robin arbiter sharing one 16:1 N-bit mux among 16 requesters, with
// bounded bursts and valid/ready output. Optional RR_ARB_GRANT_COUNT_EN adds grant_count.
module rr_mux_arbiter_16
    import rr_mux_arbiter_16_pkg::*;
#(
    parameter int N         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*N-1:0] din,
    input  logic                 out_ready,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   ack,
    output logic [SEL_W-1:0]     sel,
    output logic                 out_valid,
    output logic [N-1:0]         out_data,
    output logic                 busy
`ifdef RR_ARB_GRANT_COUNT_EN
    ,
    output logic [15:0]          grant_count
`endif
);

    localparam int BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;

    logic               found;
    logic [SEL_W-1:0]   pick_idx;
    logic [SEL_W-1:0]   pick_ptr;
    logic               transfer;
    logic               release_grant;
    logic               load_grant;
    logic [N-1:0]       din_arr [NUM_REQ];

    // A releasing grant searches from the slot after itself, so the updated
    // pointer takes effect in the same cycle rather than one cycle later.
    assign pick_ptr = busy ? next_idx(sel_q) : ptr_q;

    rr_priority_pick_16 u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .found (found),
        .idx   (pick_idx)
    );

    assign busy      = (state_q == BUSY);
    // Gated by rst_n so a reset arriving mid-burst consumes no beat.
    assign out_valid = rst_n & busy & req[sel_q];
    assign transfer  = out_valid & out_ready;
    assign ack       = gnt_q & req & {NUM_REQ{out_ready & rst_n}};

    assign release_grant = busy & (~req[sel_q] | (transfer & (beat_cnt_q == LAST_BEAT)));

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        beat_cnt_d = beat_cnt_q;
        load_grant = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) load_grant = 1'b1;
            end
            BUSY: begin
                if (release_grant) begin
                    ptr_d = pick_ptr;
                    if (found) begin
                        load_grant = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (transfer) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_grant) begin
            state_d    = BUSY;
            gnt_d      = NUM_REQ'(1) << pick_idx;
            sel_d      = pick_idx;
            beat_cnt_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            sel_q      <= '0;
            ptr_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign gnt = gnt_q;
    assign sel = sel_q;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_din_slice
        assign din_arr[g] = din[g*N +: N];
    end

    assign out_data = din_arr[sel_q];

`ifdef RR_ARB_GRANT_COUNT_EN
    logic [15:0] grant_count_q;

    always_ff @(posedge clk) begin
        if (!rst_n)          grant_count_q <= '0;
        else if (load_grant) grant_count_q <= grant_count_q + 16'd1;
    end

    assign grant_count = grant_count_q;
`endif

endmodule
